dl_line_bank: RTL and testbench

//  Parametrised bank of NCH recirculating serial delay lines, each WORDS x WORD_BITS bits long, clocked by one system clock.

---
 rtl/dl_pkg.sv | 28 ++
 rtl/dl_line_chan.sv | 104 ++++++++++
 rtl/dl_line_bank.sv | 171 +++++++++++++++++
 tb/tb_dl_line_bank.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : dl_pkg                                                  |
// | Description: Shared types and helpers for the delay-line bank:       |
// |              load FSM state encoding, line length, parity helper.    |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package dl_pkg;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_PEND  = 2'd1,
    LD_SHIFT = 2'd2
  } ld_state_t;

  // Total bits circulating in one line.
  function automatic int LINE_LEN(input int words, input int word_bits);
    return words * word_bits;
  endfunction

  // Bit that makes {bit, v} odd parity; 1 also means v itself has even parity.
  // Zero-extension of v leaves the result unchanged.
  function automatic logic odd_par(input logic [63:0] v);
    return ~^v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dl_line_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : dl_line_chan                                            |
// | Description: One recirculating serial delay line with tail-bit mux,  |
// |              sample latch and word-capture shifter.                  |
// |              Optional parity check enabled by macro DL_PARITY_EN.    |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module dl_line_chan
  import dl_pkg::*;
#(
  parameter int WORD_BITS = 28,
  parameter int WORDS     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_en,
  input  logic                 recirc_en,
  input  logic                 serial_in,
  input  logic                 ins_en,
  input  logic                 ins_bit,
  input  logic                 sample_stb,
  input  logic                 sample_clr,
  input  logic                 cap_shift,
  input  logic                 cap_last,
  output logic                 serial_out,
  output logic                 sample_q,
  output logic [WORD_BITS-1:0] cap_data,
  output logic                 par_err
);

  localparam int c_line_len = LINE_LEN(WORDS, WORD_BITS);

  logic [c_line_len-1:0] r_line;
  logic [WORD_BITS-2:0]  r_cap_sh;
  logic [WORD_BITS-1:0]  w_cap_next;
  logic                  w_tail;

  // Head of the line is bit 0; the tail enters at the top.
  assign serial_out = r_line[0];

  // Capture shifter fills LSB first, so the newest bit joins at the top.
  assign w_cap_next = {serial_out, r_cap_sh};

  // Tail source: load insertion beats serial write beats recirculation.
  always_comb begin
    w_tail = r_line[0];
    if (ins_en) begin
      w_tail = ins_bit;
    end else if (!recirc_en) begin
      w_tail = serial_in;
    end
  end

  // Line advances one bit per strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
    end else if (bit_en) begin
      r_line <= {w_tail, r_line[c_line_len-1:1]};
    end
  end

  // Sample latch: capture takes priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= 1'b0;
    end else if (sample_stb) begin
      sample_q <= serial_out;
    end else if (sample_clr) begin
      sample_q <= 1'b0;
    end
  end

  // Assemble the selected word and publish it on its last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_sh <= '0;
      cap_data <= '0;
    end else begin
      if (cap_shift) begin
        r_cap_sh <= w_cap_next[WORD_BITS-1:1];
      end
      if (cap_last) begin
        cap_data <= w_cap_next;
      end
    end
  end

`ifdef DL_PARITY_EN
  // Flag a captured word with even parity alongside the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (cap_last) begin
      par_err <= odd_par(64'(w_cap_next));
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/dl_line_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : dl_line_bank                                            |
// | Description: Bank of NCH recirculating delay lines with shared       |
// |              bit/word timing, parallel word-load FSM and word        |
// |              capture. Macro DL_PARITY_EN forces odd parity into the  |
// |              loaded MSB and checks parity of captured words.         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module dl_line_bank
  import dl_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int WORD_BITS = 28,
  parameter int WORDS     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         bit_en,
  input  logic [NCH-1:0]               recirc_en,
  input  logic [NCH-1:0]               serial_in,
  output logic [NCH-1:0]               serial_out,
  input  logic [NCH-1:0]               sample_stb,
  input  logic [NCH-1:0]               sample_clr,
  output logic [NCH-1:0]               sample_q,
  output logic [$clog2(WORD_BITS)-1:0] bit_idx,
  output logic [$clog2(WORDS)-1:0]     word_idx,
  output logic                         word_sync,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [$clog2(NCH)-1:0]       ld_ch,
  input  logic [$clog2(WORDS)-1:0]     ld_word,
  input  logic [WORD_BITS-1:0]         ld_data,
  input  logic [$clog2(WORDS)-1:0]     cap_word,
  output logic [NCH*WORD_BITS-1:0]     cap_data,
  output logic                         cap_valid,
  output logic [NCH-1:0]               par_err
);

  localparam int c_bit_w  = $clog2(WORD_BITS);
  localparam int c_word_w = $clog2(WORDS);
  localparam int c_ch_w   = $clog2(NCH);

  ld_state_t             r_state;
  logic [c_ch_w-1:0]     r_ld_ch;
  logic [c_word_w-1:0]   r_ld_word;
  logic [WORD_BITS-1:0]  r_ld_data;
  logic [c_word_w-1:0]   r_cap_word;
  logic                  r_cap_run;
  logic [WORD_BITS-1:0]  w_ld_data;
  logic                  w_last_bit;
  logic                  w_ins_active;
  logic                  w_ins_bit;
  logic                  w_cap_shift;
  logic                  w_cap_last;

  assign w_last_bit = (bit_idx == c_bit_w'(WORD_BITS - 1));
  assign word_sync  = (bit_idx == '0);

`ifdef DL_PARITY_EN
  assign w_ld_data = {odd_par(64'(ld_data[WORD_BITS-2:0])), ld_data[WORD_BITS-2:0]};
`else
  assign w_ld_data = ld_data;
`endif

  // Insertion begins on the strobe that presents bit 0 of the target slot.
  assign w_ins_active = bit_en &&
                        (((r_state == LD_PEND) && (bit_idx == '0) && (word_idx == r_ld_word)) ||
                         (r_state == LD_SHIFT));
  assign w_ins_bit    = r_ld_data[bit_idx];

  // A capture only continues a word it started at bit 0 under the same cap_word.
  assign w_cap_shift = bit_en && (word_idx == cap_word) &&
                       ((bit_idx == '0) || (r_cap_run && (cap_word == r_cap_word)));
  assign w_cap_last  = w_cap_shift && w_last_bit;

  // Bit/word position of the bit currently at the line heads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx  <= '0;
      word_idx <= '0;
    end else if (bit_en) begin
      if (w_last_bit) begin
        bit_idx  <= '0;
        word_idx <= (word_idx == c_word_w'(WORDS - 1)) ? '0 : word_idx + 1'b1;
      end else begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Parallel load: latch request, wait for slot bit 0, insert one full word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LD_IDLE;
      ld_ready  <= 1'b1;
      r_ld_ch   <= '0;
      r_ld_word <= '0;
      r_ld_data <= '0;
    end else begin
      case (r_state)
        LD_IDLE: begin
          if (ld_valid) begin
            r_ld_ch   <= ld_ch;
            r_ld_word <= ld_word;
            r_ld_data <= w_ld_data;
            ld_ready  <= 1'b0;
            r_state   <= LD_PEND;
          end
        end
        LD_PEND: begin
          if (w_ins_active) begin
            r_state <= LD_SHIFT;
          end
        end
        LD_SHIFT: begin
          if (bit_en && w_last_bit) begin
            ld_ready <= 1'b1;
            r_state  <= LD_IDLE;
          end
        end
        default: begin
          ld_ready <= 1'b1;
          r_state  <= LD_IDLE;
        end
      endcase
    end
  end

  // Capture progress tracking and the one-cycle capture pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_word <= '0;
      r_cap_run  <= 1'b0;
      cap_valid  <= 1'b0;
    end else begin
      r_cap_word <= cap_word;
      cap_valid  <= w_cap_last;
      if (bit_en) begin
        r_cap_run <= w_cap_shift && !w_last_bit;
      end else if (cap_word != r_cap_word) begin
        r_cap_run <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    dl_line_chan #(
      .WORD_BITS (WORD_BITS),
      .WORDS     (WORDS)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_en     (bit_en),
      .recirc_en  (recirc_en[g]),
      .serial_in  (serial_in[g]),
      .ins_en     (w_ins_active && (r_ld_ch == c_ch_w'(g))),
      .ins_bit    (w_ins_bit),
      .sample_stb (sample_stb[g]),
      .sample_clr (sample_clr[g]),
      .cap_shift  (w_cap_shift),
      .cap_last   (w_cap_last),
      .serial_out (serial_out[g]),
      .sample_q   (sample_q[g]),
      .cap_data   (cap_data[g*WORD_BITS +: WORD_BITS]),
      .par_err    (par_err[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_dl_line_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_dl_line_bank                                         |
// | Description: Directed self-checking bench for dl_line_bank with a    |
// |              queue of expected results. Honours DL_PARITY_EN.        |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_dl_line_bank;

  localparam int NCH = 2;
  localparam int WB  = 28;
  localparam int WDS = 4;
`ifdef DL_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            bit_en;
  logic [NCH-1:0]  recirc_en, serial_in, serial_out;
  logic [NCH-1:0]  sample_stb, sample_clr, sample_q;
  logic [4:0]      bit_idx;
  logic [1:0]      word_idx;
  logic            word_sync;
  logic            ld_valid, ld_ready;
  logic            ld_ch;
  logic [1:0]      ld_word;
  logic [WB-1:0]   ld_data;
  logic [1:0]      cap_word;
  logic [NCH*WB-1:0] cap_data;
  logic            cap_valid;
  logic [NCH-1:0]  par_err;

  int checks  = 0;
  int passes  = 0;
  int fails   = 0;
  int strobes = 0;
  logic [63:0] sb[$];

  dl_line_bank #(.NCH(NCH), .WORD_BITS(WB), .WORDS(WDS)) dut (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en),
    .recirc_en(recirc_en), .serial_in(serial_in), .serial_out(serial_out),
    .sample_stb(sample_stb), .sample_clr(sample_clr), .sample_q(sample_q),
    .bit_idx(bit_idx), .word_idx(word_idx), .word_sync(word_sync),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_ch(ld_ch),
    .ld_word(ld_word), .ld_data(ld_data), .cap_word(cap_word),
    .cap_data(cap_data), .cap_valid(cap_valid), .par_err(par_err)
  );

  always #5 clk = ~clk;

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    logic be;
    be = bit_en & rst_n;
    @(posedge clk);
    #1;
    if (be) strobes++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    exp = (sb.size() != 0) ? sb.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    check(tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; bit_en = 1'b0; recirc_en = '1; serial_in = '0;
    sample_stb = '0; sample_clr = '0; ld_valid = 1'b0; ld_ch = 1'b0;
    ld_word = '0; ld_data = '0; cap_word = '0;
    step(); step();

    // Reset state
    check("rst_bit_idx", 64'(bit_idx), 0);
    check("rst_word_idx", 64'(word_idx), 0);
    check("rst_word_sync", 64'(word_sync), 1);
    check("rst_ld_ready", 64'(ld_ready), 1);
    check("rst_cap_valid", 64'(cap_valid), 0);
    check("rst_cap_data", 64'(cap_data), 0);
    check("rst_par_err", 64'(par_err), 0);
    check("rst_serial_out", 64'(serial_out), 0);
    check("rst_sample_q", 64'(sample_q), 0);

    // Timing counters over one full revolution
    rst_n = 1'b1; bit_en = 1'b1; strobes = 0;
    for (int i = 0; i < WB * WDS; i++) begin
      step();
      check("cnt_bit_idx", 64'(bit_idx), 64'(strobes % WB));
      check("cnt_word_idx", 64'(word_idx), 64'((strobes / WB) % WDS));
      check("cnt_word_sync", 64'(word_sync), 64'((strobes % WB) == 0));
      if (i == WB - 1) check("cnt_word1", 64'(word_idx), 1);
    end
    check("cnt_wrap_word0", 64'(word_idx), 0);

    // Serial write of one bit into ch0 at word 0 bit 0
    recirc_en = 2'b10; serial_in = 2'b01;
    sb.push_back(64'h1);
    step();
    recirc_en = 2'b11; serial_in = 2'b00;
    for (int i = 0; i < WB * WDS - 2; i++) step();
    check("wr_early", 64'(serial_out), 0);
    step();
    check_pop("wr_out", 64'(serial_out));

    // Sample latch: strobe and clear together, then clear alone
    sample_stb = 2'b01; sample_clr = 2'b01;
    sb.push_back(64'h1);
    step();
    sample_stb = 2'b00;
    check_pop("samp_both", 64'(sample_q));
    sb.push_back(64'h0);
    step();
    sample_clr = 2'b00;
    check_pop("samp_clr", 64'(sample_q));

    // Parallel load into ch1 word 2, captured via cap_word 2
    cap_word = 2'd2; ld_ch = 1'b1; ld_word = 2'd2; ld_data = 28'h0ABCDEF; ld_valid = 1'b1;
    sb.push_back({8'h0, 28'h0ABCDEF, 28'h0});
    step();
    check("ld_busy", 64'(ld_ready), 0);
    ld_ch = 1'b0; ld_data = 28'h1234567;
    step();
    ld_valid = 1'b0;
    for (int n = 0; n < 300 && !ld_ready; n++) step();
    check("ld_done", 64'(ld_ready), 1);
    check("cap_old_pulse", 64'(cap_valid), 1);
    check("cap_old_ch1", 64'(cap_data[2*WB-1:WB]), 0);
    step();
    for (int n = 0; n < 200 && !cap_valid; n++) step();
    check("cap_ld_valid", 64'(cap_valid), 1);
    check_pop("cap_ld_data", 64'(cap_data));
    check("cap_ld_par", 64'(par_err), PAR ? 64'h1 : 64'h0);
    step();
    check("cap_pulse_end", 64'(cap_valid), 0);

    // Reset in the middle of an insertion into ch0 word 1
    ld_ch = 1'b0; ld_word = 2'd1; ld_data = 28'hFFFFFFF; ld_valid = 1'b1;
    step();
    ld_valid = 1'b0;
    for (int n = 0; n < 300 && !(word_idx == 2'd1 && bit_idx == 5'd10); n++) step();
    check("mid_shift_busy", 64'(ld_ready), 0);
    rst_n = 1'b0;
    #1;
    strobes = 0;
    check("mrst_ld_ready", 64'(ld_ready), 1);
    check("mrst_bit_idx", 64'(bit_idx), 0);
    check("mrst_serial_out", 64'(serial_out), 0);
    step();
    rst_n = 1'b1;
    step(); step(); step();
    bit_en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("freeze_bit_idx", 64'(bit_idx), 3);
    check("freeze_word_idx", 64'(word_idx), 0);
    bit_en = 1'b1;
    cap_word = 2'd1;
    sb.push_back(64'h0);
    for (int n = 0; n < 200 && !cap_valid; n++) step();
    check("clr_cap_valid", 64'(cap_valid), 1);
    check_pop("clr_cap_data", 64'(cap_data));
    check("clr_par", 64'(par_err), PAR ? 64'h3 : 64'h0);
    check("clr_ld_ready", 64'(ld_ready), 1);

    // MSB handling of loaded data, then a serial write disturbing parity
    cap_word = 2'd3; ld_ch = 1'b0; ld_word = 2'd3; ld_data = 28'h8000001; ld_valid = 1'b1;
    sb.push_back(64'(PAR ? 28'h0000001 : 28'h8000001));
    step();
    ld_valid = 1'b0;
    for (int n = 0; n < 300 && !ld_ready; n++) step();
    check("msb_ld_done", 64'(ld_ready), 1);
    step();
    for (int n = 0; n < 200 && !cap_valid; n++) step();
    check_pop("msb_cap_data", 64'(cap_data));
    check("msb_par", 64'(par_err), PAR ? 64'h2 : 64'h0);
    for (int n = 0; n < 200 && !(word_idx == 2'd3 && bit_idx == 5'd5); n++) step();
    recirc_en = 2'b10; serial_in = 2'b01;
    sb.push_back(64'(PAR ? 28'h0000021 : 28'h8000021));
    step();
    recirc_en = 2'b11; serial_in = 2'b00;
    for (int n = 0; n < 200 && !cap_valid; n++) step();
    step();
    for (int n = 0; n < 200 && !cap_valid; n++) step();
    check_pop("ser_cap_data", 64'(cap_data));
    check("ser_par", 64'(par_err), PAR ? 64'h3 : 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
